// File: rtl/marker_corner_finder.sv
// marker_corner_finder: classifies raster pixels as red markers and reports the four extreme marker addresses per frame
// i_clk/i_rst_n: clock, async active-low reset; i_valid/i_data: pixel beat {2'b0,R,G,B}; i_sync: frame restart
// o_addr_valid: end-of-frame pulse; o_ul/ur/dl/dr_addr: {row,col} corners; o_found: marker count >= MIN_PIXELS
module marker_corner_finder #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter logic [9:0] R_MIN = 10'd600,
  parameter logic [9:0] G_MAX = 10'd300,
  parameter logic [9:0] B_MAX = 10'd300,
  parameter int MIN_PIXELS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        i_sync,
  output logic        o_addr_valid,
  output logic [19:0] o_ul_addr,
  output logic [19:0] o_ur_addr,
  output logic [19:0] o_dl_addr,
  output logic [19:0] o_dr_addr,
  output logic        o_found
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);
  logic [9:0] col, row, b_col, b_row, s1_row, s1_col;
  logic mk, s1_v, s1_mk, s1_last, hit, eof, empty, unused;
  logic [19:0] px, ul, ur, dl, dr, n_ul, n_ur, n_dl, n_dr, cnt, n_cnt;
  function automatic logic [10:0] k_ul(input logic [19:0] a);
    return {1'b0, a[19:10]} + {1'b0, a[9:0]};
  endfunction
  function automatic logic [10:0] k_ur(input logic [19:0] a);
    return {1'b0, a[9:0]} + {1'b0, V_LAST - a[19:10]};
  endfunction
  function automatic logic [10:0] k_dl(input logic [19:0] a);
    return {1'b0, a[19:10]} + {1'b0, H_LAST - a[9:0]};
  endfunction
  assign unused = ^i_data[31:30];
  // a beat arriving with i_sync is pixel (0,0) of the new frame
  always_comb begin
    b_col = i_sync ? '0 : col;
    b_row = i_sync ? '0 : row;
    mk = i_data[29:20] >= R_MIN && i_data[19:10] < G_MAX && i_data[9:0] < B_MAX;
    hit = s1_v && s1_mk;
    eof = s1_v && s1_last;
    px = {s1_row, s1_col};
    n_ul = hit && (empty || k_ul(px) < k_ul(ul)) ? px : ul;
    n_dr = hit && (empty || k_ul(px) > k_ul(dr)) ? px : dr;
    n_ur = hit && (empty || k_ur(px) > k_ur(ur)) ? px : ur;
    n_dl = hit && (empty || k_dl(px) > k_dl(dl)) ? px : dl;
    n_cnt = hit && cnt != '1 ? cnt + 20'd1 : cnt;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col <= '0;
      row <= '0;
      s1_v <= 1'b0;
      s1_mk <= 1'b0;
      s1_last <= 1'b0;
      s1_row <= '0;
      s1_col <= '0;
    end else begin
      if (i_valid) begin
        col <= b_col == H_LAST ? '0 : b_col + 10'd1;
        row <= b_col == H_LAST ? (b_row == V_LAST ? '0 : b_row + 10'd1) : b_row;
      end else if (i_sync) begin
        col <= '0;
        row <= '0;
      end
      s1_v <= i_valid;
      s1_mk <= mk;
      s1_row <= b_row;
      s1_col <= b_col;
      s1_last <= b_row == V_LAST && b_col == H_LAST;
    end
  end
  // a frame end still reports in a sync cycle; a sync only discards the in-flight non-last pixel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_addr_valid <= 1'b0;
      o_found <= 1'b0;
      o_ul_addr <= '0;
      o_ur_addr <= '0;
      o_dl_addr <= '0;
      o_dr_addr <= '0;
      ul <= '0;
      ur <= '0;
      dl <= '0;
      dr <= '0;
      cnt <= '0;
      empty <= 1'b1;
    end else begin
      o_addr_valid <= eof;
      if (eof) begin
        o_found <= n_cnt >= 20'(MIN_PIXELS);
        if (n_cnt != '0) begin
          o_ul_addr <= n_ul;
          o_ur_addr <= n_ur;
          o_dl_addr <= n_dl;
          o_dr_addr <= n_dr;
        end
      end
      if (i_sync || eof) begin
        ul <= '0;
        ur <= '0;
        dl <= '0;
        dr <= '0;
        cnt <= '0;
        empty <= 1'b1;
      end else begin
        ul <= n_ul;
        ur <= n_ur;
        dl <= n_dl;
        dr <= n_dr;
        cnt <= n_cnt;
        empty <= empty && !hit;
      end
    end
  end
endmodule

// File: tb/tb_marker_corner_finder.sv
// tb_marker_corner_finder: directed frames on a reduced 40x30 raster with hand-computed corner expectations
module tb_marker_corner_finder;
  localparam int H = 40;
  localparam int V = 30;
  logic i_clk = 0, i_rst_n = 0, i_valid = 0, i_sync = 0;
  logic [31:0] i_data = '0;
  logic o_addr_valid, o_found;
  logic [19:0] o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr;
  int checks = 0, errors = 0, cyc = 0, pulses = 0, pulse_cyc = -1, last_cyc = 0;
  marker_corner_finder #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data), .i_sync(i_sync),
    .o_addr_valid(o_addr_valid), .o_ul_addr(o_ul_addr), .o_ur_addr(o_ur_addr),
    .o_dl_addr(o_dl_addr), .o_dr_addr(o_dr_addr), .o_found(o_found)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) if (o_addr_valid) begin
    pulses <= pulses + 1;
    pulse_cyc <= cyc;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
  function automatic logic [19:0] pk(input int r, input int c);
    return {r[9:0], c[9:0]};
  endfunction
  // pat 0 none, 1 square rows 10-13 cols 20-23, 2 three sparse points, 3 UL tie, 4 corners for aborted frames
  function automatic logic [31:0] pix(input int pat, input int r, input int c);
    bit red;
    case (pat)
      1: red = r >= 10 && r <= 13 && c >= 20 && c <= 23;
      2: red = (r == 2 && c == 2) || (r == 2 && c == 35) || (r == 25 && c == 2);
      3: red = (r == 3 && c == 5) || (r == 5 && c == 3);
      4: red = (r == 0 && c == 0) || (r == 14 && c == 39);
      default: red = 0;
    endcase
    if (red) return ((r + c) % 2 == 1) ? {2'b0, 10'd600, 10'd299, 10'd299} : {2'b0, 10'd1023, 10'd0, 10'd0};
    case ((r + c) % 3)
      0: return {2'b0, 10'd599, 10'd0, 10'd0};
      1: return {2'b0, 10'd1023, 10'd300, 10'd0};
      default: return {2'b0, 10'd1023, 10'd0, 10'd300};
    endcase
  endfunction
  task automatic run_frame(input int pat, input bit gaps, input int stop_row, input bit sync_first);
    for (int r = 0; r < V; r++) for (int c = 0; c < H; c++) begin
      if (r == stop_row) begin
        i_valid = 0;
        return;
      end
      if (gaps) while ($urandom_range(0, 1) == 1) begin
        i_valid = 0;
        @(posedge i_clk); #1;
      end
      i_valid = 1;
      i_sync = sync_first && r == 0 && c == 0;
      i_data = pix(pat, r, c);
      @(posedge i_clk); #1;
      i_sync = 0;
      last_cyc = cyc;
    end
    i_valid = 0;
  endtask
  task automatic settle();
    repeat (4) @(posedge i_clk);
    #1;
  endtask
  task automatic test_reset();
    i_rst_n = 0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++; if ({o_addr_valid, o_found} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {o_addr_valid, o_found}); end
    checks++; if ({o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr} !== 80'd0) begin errors++; $display("FAIL reset_addrs: got %h expected 0", {o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr}); end
    i_rst_n = 1;
    @(posedge i_clk); #1;
  endtask
  task automatic test_no_red();
    int p0;
    p0 = pulses;
    run_frame(0, 0, -1, 0);
    settle();
    checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL no_red_pulses: got %0d expected %0d", pulses - p0, 1); end
    checks++; if (pulse_cyc !== last_cyc + 1) begin errors++; $display("FAIL no_red_latency: got cycle %0d expected %0d", pulse_cyc, last_cyc + 1); end
    checks++; if (o_found !== 1'b0) begin errors++; $display("FAIL no_red_found: got %b expected 0", o_found); end
    checks++; if ({o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr} !== 80'd0) begin errors++; $display("FAIL no_red_addrs: got %h expected 0", {o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr}); end
  endtask
  task automatic test_square(input bit gaps);
    int p0;
    p0 = pulses;
    run_frame(1, gaps, -1, 0);
    settle();
    checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL square_pulses(gaps=%0d): got %0d expected 1", gaps, pulses - p0); end
    checks++; if (pulse_cyc !== last_cyc + 1) begin errors++; $display("FAIL square_latency(gaps=%0d): got cycle %0d expected %0d", gaps, pulse_cyc, last_cyc + 1); end
    checks++; if (o_found !== 1'b1) begin errors++; $display("FAIL square_found(gaps=%0d): got %b expected 1", gaps, o_found); end
    checks++; if (o_ul_addr !== pk(10, 20)) begin errors++; $display("FAIL square_ul(gaps=%0d): got %h expected %h", gaps, o_ul_addr, pk(10, 20)); end
    checks++; if (o_ur_addr !== pk(10, 23)) begin errors++; $display("FAIL square_ur(gaps=%0d): got %h expected %h", gaps, o_ur_addr, pk(10, 23)); end
    checks++; if (o_dl_addr !== pk(13, 20)) begin errors++; $display("FAIL square_dl(gaps=%0d): got %h expected %h", gaps, o_dl_addr, pk(13, 20)); end
    checks++; if (o_dr_addr !== pk(13, 23)) begin errors++; $display("FAIL square_dr(gaps=%0d): got %h expected %h", gaps, o_dr_addr, pk(13, 23)); end
  endtask
  task automatic test_hold_empty();
    int p0;
    p0 = pulses;
    run_frame(0, 0, -1, 0);
    settle();
    checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL hold_pulses: got %0d expected 1", pulses - p0); end
    checks++; if (o_found !== 1'b0) begin errors++; $display("FAIL hold_found: got %b expected 0", o_found); end
    checks++; if ({o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr} !== {pk(10, 20), pk(10, 23), pk(13, 20), pk(13, 23)}) begin errors++; $display("FAIL hold_addrs: got %h expected %h", {o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr}, {pk(10, 20), pk(10, 23), pk(13, 20), pk(13, 23)}); end
  endtask
  task automatic test_sparse();
    run_frame(2, 0, -1, 0);
    settle();
    checks++; if (o_found !== 1'b0) begin errors++; $display("FAIL sparse_found: got %b expected 0", o_found); end
    checks++; if (o_ul_addr !== pk(2, 2)) begin errors++; $display("FAIL sparse_ul: got %h expected %h", o_ul_addr, pk(2, 2)); end
    checks++; if (o_ur_addr !== pk(2, 35)) begin errors++; $display("FAIL sparse_ur: got %h expected %h", o_ur_addr, pk(2, 35)); end
    checks++; if (o_dl_addr !== pk(25, 2)) begin errors++; $display("FAIL sparse_dl: got %h expected %h", o_dl_addr, pk(25, 2)); end
    checks++; if (o_dr_addr !== pk(2, 35)) begin errors++; $display("FAIL sparse_dr: got %h expected %h", o_dr_addr, pk(2, 35)); end
  endtask
  task automatic test_tie();
    run_frame(3, 0, -1, 0);
    settle();
    checks++; if (o_ul_addr !== pk(3, 5)) begin errors++; $display("FAIL tie_ul: got %h expected %h", o_ul_addr, pk(3, 5)); end
    checks++; if (o_dr_addr !== pk(3, 5)) begin errors++; $display("FAIL tie_dr: got %h expected %h", o_dr_addr, pk(3, 5)); end
    checks++; if (o_ur_addr !== pk(3, 5)) begin errors++; $display("FAIL tie_ur: got %h expected %h", o_ur_addr, pk(3, 5)); end
    checks++; if (o_dl_addr !== pk(5, 3)) begin errors++; $display("FAIL tie_dl: got %h expected %h", o_dl_addr, pk(5, 3)); end
  endtask
  task automatic test_sync();
    int p0;
    p0 = pulses;
    run_frame(4, 0, 15, 0);
    run_frame(1, 0, -1, 1);
    settle();
    checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL sync_pulses: got %0d expected 1", pulses - p0); end
    checks++; if (o_found !== 1'b1) begin errors++; $display("FAIL sync_found: got %b expected 1", o_found); end
    checks++; if ({o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr} !== {pk(10, 20), pk(10, 23), pk(13, 20), pk(13, 23)}) begin errors++; $display("FAIL sync_addrs: got %h expected %h", {o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr}, {pk(10, 20), pk(10, 23), pk(13, 20), pk(13, 23)}); end
  endtask
  task automatic test_async_reset();
    int p0;
    run_frame(4, 0, 12, 0);
    i_rst_n = 0;
    #1;
    checks++; if ({o_addr_valid, o_found, o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr} !== 82'd0) begin errors++; $display("FAIL async_reset_now: got %h expected 0", {o_addr_valid, o_found, o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr}); end
    @(posedge i_clk); #1;
    checks++; if ({o_addr_valid, o_found, o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr} !== 82'd0) begin errors++; $display("FAIL async_reset_next: got %h expected 0", {o_addr_valid, o_found, o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr}); end
    i_rst_n = 1;
    @(posedge i_clk); #1;
    p0 = pulses;
    run_frame(1, 0, -1, 0);
    settle();
    checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL after_reset_pulses: got %0d expected 1", pulses - p0); end
    checks++; if (o_found !== 1'b1) begin errors++; $display("FAIL after_reset_found: got %b expected 1", o_found); end
    checks++; if ({o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr} !== {pk(10, 20), pk(10, 23), pk(13, 20), pk(13, 23)}) begin errors++; $display("FAIL after_reset_addrs: got %h expected %h", {o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr}, {pk(10, 20), pk(10, 23), pk(13, 20), pk(13, 23)}); end
  endtask
  initial begin
    test_reset();
    test_no_red();
    test_square(0);
    test_hold_empty();
    test_sparse();
    test_tie();
    test_square(1);
    test_sync();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
